systolic_result_drain: RTL

- Output-side counterpart to the systolic array's input rearrangement.
- Snapshots the M x P result matrix when the array signals completion, then serializes it in row-major order over a valid/ready stream.
- Sits between the systolic array top's result and finish outputs and the downstream consumer (writeback or FIFO).
- Decouples array completion from consumer back-pressure.

---
 rtl/systolic_result_drain_if.sv | 34 +++
 rtl/systolic_result_drain.sv | 126 ++++++++++++
 2 files changed

// File: rtl/systolic_result_drain_if.sv
// Result-drain bus: matrix capture inputs from the array plus the row-major
// valid/ready element stream and status flags toward the consumer.
interface systolic_result_drain_if #(
  parameter int unsigned BW = 16,
  parameter int unsigned M  = 3,
  parameter int unsigned P  = 5
);
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;

  logic [BW-1:0] res [M][P];
  logic          finished;
  logic [BW-1:0] data;
  logic          valid;
  logic          ready;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          last;
  logic          busy;
  logic          done;
  logic          overrun;

  // Drain block side
  modport master (
    input  res, finished, ready,
    output data, valid, row, col, last, busy, done, overrun
  );

  // Array / consumer side
  modport slave (
    output res, finished, ready,
    input  data, valid, row, col, last, busy, done, overrun
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures the M x P result matrix on the array's completion edge and streams it
// out in row-major order over valid/ready, decoupling completion from back-pressure.
module systolic_result_drain #(
  parameter int unsigned BW = 16,
  parameter int unsigned M  = 3,
  parameter int unsigned P  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_result_drain_if.master bus
);
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(P - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          fin_q;
  logic [BW-1:0] snap [M][P];

  logic          rise, capture;
  logic [RW-1:0] row_d, nrow;
  logic [CW-1:0] col_d, ncol;
  logic [BW-1:0] data_d;
  logic          valid_d, last_d, busy_d, done_d, overrun_d;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    row_d     = bus.row;
    col_d     = bus.col;
    nrow      = bus.row;
    ncol      = bus.col;
    data_d    = bus.data;
    valid_d   = bus.valid;
    last_d    = bus.last;
    busy_d    = bus.busy;
    done_d    = 1'b0;
    overrun_d = bus.overrun;
    capture   = 1'b0;
    rise      = bus.finished && !fin_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          capture = 1'b1;
          row_d   = '0;
          col_d   = '0;
          data_d  = bus.res[0][0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = (ROW_LAST == '0) && (COL_LAST == '0);
          state_d = STREAM;
        end
      end
      STREAM: begin
        // A new completion while draining is flagged but never recaptured
        if (rise) overrun_d = 1'b1;
        if (bus.valid && bus.ready) begin
          if (bus.last) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
            state_d = IDLE;
          end else begin
            if (bus.col == COL_LAST) begin
              ncol = '0;
              nrow = bus.row + RW'(1);
            end else begin
              ncol = bus.col + CW'(1);
            end
            row_d  = nrow;
            col_d  = ncol;
            data_d = snap[nrow][ncol];
            last_d = (nrow == ROW_LAST) && (ncol == COL_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, edge detector and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fin_q       <= 1'b0;
      bus.row     <= '0;
      bus.col     <= '0;
      bus.data    <= '0;
      bus.valid   <= 1'b0;
      bus.last    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      fin_q       <= bus.finished;
      bus.row     <= row_d;
      bus.col     <= col_d;
      bus.data    <= data_d;
      bus.valid   <= valid_d;
      bus.last    <= last_d;
      bus.busy    <= busy_d;
      bus.done    <= done_d;
      bus.overrun <= overrun_d;
    end
  end

  // Snapshot needs no reset; it is only read after a capture
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned r = 0; r < M; r++) begin
        for (int unsigned c = 0; c < P; c++) begin
          snap[r][c] <= bus.res[r][c];
        end
      end
    end
  end
endmodule
